// File: rtl/key_event_pkg.sv
// key_event_pkg
// Shared types and helpers for the keypad event queue.
//   CODE_W         : width of a key code (4 -> 16 keys)
//   NKEYS_MAX      : largest key vector a code can address
//   key_event_t    : {code, press} event as stored in the FIFO (5 bits)
//   emit_state_e   : serialiser FSM states (IDLE, EMIT)
//   lowest_set_bit : index of the least-significant set bit of a key vector
package key_event_pkg;

    localparam int CODE_W    = 4;
    localparam int NKEYS_MAX = 1 << CODE_W;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              press;
    } key_event_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } emit_state_e;

    // Scanning from the top down lets the lowest set bit overwrite any
    // higher one, so the result is the lowest index. An all-zero vector
    // returns 0.
    function automatic logic [CODE_W-1:0] lowest_set_bit(input logic [NKEYS_MAX-1:0] vec);
        lowest_set_bit = '0;
        for (int i = NKEYS_MAX - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set_bit = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
// Synchronous FIFO with a registered head word.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wr_data; accepted when not full, or when full and a
//              pop happens in the same cycle
//   wr_data  : word to write
//   pop      : remove the head word (ignored while empty)
//   head     : registered head word, valid while !empty
//   full     : DEPTH words stored
//   empty    : no words stored
module key_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = head_q;

    // NOTE: every signal written here is assigned on every path, so no
    // latch can be inferred.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        // Head register tracks the word that will sit at rd_ptr_d after
        // this edge; a word written into that slot right now bypasses memory.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_data;
        end else if (count_d == '0) begin
            head_d = head_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update
    // together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and count decide
    // which words are meaningful, and the visible head is a reset register.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue
// Debounces the keypad scanner's key vector, turns accepted changes into
// per-key events (lowest index first, one per clock) and queues them.
//   clk, rst    : clock, asynchronous active-high reset
//   key_state   : latched key vector from the scanner (bit n = key n held)
//   scan_done   : one-cycle strobe, key_state is a complete sweep
//   ev_valid    : head event available
//   ev_ready    : consumer takes the head event
//   ev_code     : key index of the head event
//   ev_press    : 1 = press, 0 = release
//   stable_keys : debounced key vector
//   overflow    : sticky, an event was dropped on a full queue
//   ovf_clr     : clears overflow (a simultaneous drop wins)
// Build option: define KEY_EVENT_RELEASE_EN to queue release events too;
// without it only presses are queued and ev_press is tied to 1.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int NKEYS          = 16,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NKEYS-1:0]  key_state,
    input  logic              scan_done,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_press,
    output logic [NKEYS-1:0]  stable_keys,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SAT_CNT    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(DEBOUNCE_SCANS - 1);
`ifdef KEY_EVENT_RELEASE_EN
    localparam int EV_W = $bits(key_event_t);
`else
    localparam int EV_W = CODE_W;
`endif

    emit_state_e      state_q, state_d;
    logic [NKEYS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NKEYS-1:0] stable_q, stable_d;
    logic [NKEYS-1:0] diff_q, diff_d;
    logic [NKEYS-1:0] snap_q, snap_d;
    logic             ovf_q, ovf_d;

    logic              accept, last_bit, emit_push, ev_drop;
    logic [CODE_W-1:0] lsb_code;
    logic [NKEYS-1:0]  diff_rest;
    logic [EV_W-1:0]   fifo_wr, fifo_head;
    logic              fifo_full, fifo_empty;

    // Debounce: a new vector restarts the count, a repeat counts up and
    // saturates. Runs regardless of FSM state.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (scan_done) begin
            if (key_state != cand_q) begin
                cand_d = key_state;
                cnt_d  = '0;
            end else if (cnt_q != SAT_CNT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign accept    = (state_q == IDLE) && (cnt_q >= ACCEPT_CNT) && (cand_q != stable_q);
    assign lsb_code  = lowest_set_bit(NKEYS_MAX'(diff_q));
    assign diff_rest = diff_q & (diff_q - 1'b1);   // diff with its lowest set bit cleared
    assign last_bit  = (diff_rest == '0);

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EMIT;
            EMIT:    if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: snapshot on accept, peel one diff bit per EMIT cycle.
    always_comb begin
        stable_d = stable_q;
        snap_d   = snap_q;
        diff_d   = diff_q;
        if (accept) begin
            diff_d   = cand_q ^ stable_q;
            snap_d   = cand_q;
            stable_d = cand_q;
        end else if (state_q == EMIT) begin
            diff_d = diff_rest;
        end
    end

    // FSM outputs
    always_comb begin
        emit_push = 1'b0;
        if (state_q == EMIT) begin
`ifdef KEY_EVENT_RELEASE_EN
            emit_push = 1'b1;
`else
            emit_push = snap_q[lsb_code];
`endif
        end
    end

    // A push is lost only when the queue is full and nothing leaves it.
    assign ev_drop = emit_push && fifo_full && !ev_ready;

    always_comb begin
        ovf_d = ev_drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            diff_q   <= '0;
            snap_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            diff_q   <= diff_d;
            snap_q   <= snap_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef KEY_EVENT_RELEASE_EN
    key_event_t ev_in, ev_head;
    always_comb begin
        ev_in.code  = lsb_code;
        ev_in.press = snap_q[lsb_code];
    end
    assign fifo_wr  = ev_in;
    assign ev_head  = key_event_t'(fifo_head);
    assign ev_code  = ev_head.code;
    assign ev_press = ev_head.press;
`else
    assign fifo_wr  = lsb_code;
    assign ev_code  = fifo_head;
    assign ev_press = 1'b1;
`endif

    key_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (emit_push),
        .wr_data (fifo_wr),
        .pop     (ev_ready),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid    = !fifo_empty;
    assign stable_keys = stable_q;
    assign overflow    = ovf_q;

endmodule
